// File: rtl/jt49_tdm_if.sv
// Register bus for jt49_tdm: write strobe/address/data in, registered read data out.
interface jt49_tdm_if;
  logic [6:0] addr;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output addr, wr, din, input dout);
  modport slave  (input addr, wr, din, output dout);
endinterface

// File: rtl/jt49_tdm.sv
// Time-multiplexed PSG tone mixer: one channel serviced per cen, one sample per frame.
// Define JT49_TDM_NOISE_EN to build the LFSR noise generator (register 0x40).
module jt49_tdm #(
  parameter  int CH = 3,
  localparam int DW = 4 + $clog2(CH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  jt49_tdm_if.slave     bus,
  output logic [DW-1:0] sound,
  output logic          sample_v
);

  localparam int            KW    = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(CH - 1);

  logic [11:0]   period   [CH];
  logic [3:0]    vol      [CH];
  logic          noise_en [CH];
  logic          tone_dis [CH];
  logic [11:0]   cnt      [CH];
  logic          tone     [CH];
  logic [KW-1:0] k;
  logic [DW-1:0] acc;
  logic [7:0]    rd;
  logic          noise;
  logic          frame_end;

  logic [11:0]   cur_per;
  logic [11:0]   cur_cnt;
  logic [11:0]   peff;
  logic          cur_tone;
  logic [3:0]    cur_vol;
  logic          cur_ne;
  logic          cur_td;
  logic          wrap;
  logic          tone_new;
  logic [DW-1:0] contrib;

`ifdef JT49_TDM_NOISE_EN
  logic [4:0]  noise_per;
  logic [4:0]  ndiv;
  logic [16:0] lfsr;
  logic [4:0]  npeff;

  assign npeff = (noise_per == 5'd0) ? 5'd1 : noise_per;
  assign noise = lfsr[0];

  // The noise divider ticks once per frame, so noise is constant across a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      noise_per <= 5'd0;
      ndiv      <= 5'd0;
      lfsr      <= 17'h1;
    end else begin
      if (bus.wr && bus.addr == 7'h40)
        noise_per <= bus.din[4:0];
      if (frame_end) begin
        if ({1'b0, ndiv} + 6'd1 >= {1'b0, npeff}) begin
          ndiv <= 5'd0;
          lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
        end else begin
          ndiv <= ndiv + 5'd1;
        end
      end
    end
  end
`else
  assign noise = 1'b1;
`endif

  assign frame_end = cen && (k == KLAST);

  always_comb begin
    rd = 8'h00;
    for (int n = 0; n < CH; n++) begin
      if (!bus.addr[6] && bus.addr[5:2] == 4'(n)) begin
        case (bus.addr[1:0])
          2'd0:    rd = period[n][7:0];
          2'd1:    rd = {4'h0, period[n][11:8]};
          2'd2:    rd = {2'b00, tone_dis[n], noise_en[n], vol[n]};
          default: rd = 8'h00;
        endcase
      end
    end
`ifdef JT49_TDM_NOISE_EN
    if (bus.addr == 7'h40)
      rd = {3'b000, noise_per};
`endif
  end

  always_comb begin
    cur_per  = 12'd0;
    cur_cnt  = 12'd0;
    cur_tone = 1'b0;
    cur_vol  = 4'd0;
    cur_ne   = 1'b0;
    cur_td   = 1'b0;
    for (int n = 0; n < CH; n++) begin
      if (k == KW'(n)) begin
        cur_per  = period[n];
        cur_cnt  = cnt[n];
        cur_tone = tone[n];
        cur_vol  = vol[n];
        cur_ne   = noise_en[n];
        cur_td   = tone_dis[n];
      end
    end
  end

  // The >= compare also recovers a counter left above a freshly lowered period.
  assign peff     = (cur_per == 12'd0) ? 12'd1 : cur_per;
  assign wrap     = ({1'b0, cur_cnt} + 13'd1) >= {1'b0, peff};
  assign tone_new = cur_tone ^ wrap;
  assign contrib  = ((tone_new | cur_td) & (noise | ~cur_ne)) ? DW'(cur_vol) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < CH; n++) begin
        period[n]   <= 12'd0;
        vol[n]      <= 4'd0;
        noise_en[n] <= 1'b0;
        tone_dis[n] <= 1'b0;
        cnt[n]      <= 12'd0;
        tone[n]     <= 1'b0;
      end
      k        <= '0;
      acc      <= '0;
      sound    <= '0;
      sample_v <= 1'b0;
      bus.dout <= 8'h00;
    end else begin
      bus.dout <= rd;
      sample_v <= 1'b0;
      if (bus.wr) begin
        for (int n = 0; n < CH; n++) begin
          if (!bus.addr[6] && bus.addr[5:2] == 4'(n)) begin
            case (bus.addr[1:0])
              2'd0: period[n][7:0]  <= bus.din;
              2'd1: period[n][11:8] <= bus.din[3:0];
              2'd2: begin
                vol[n]      <= bus.din[3:0];
                noise_en[n] <= bus.din[4];
                tone_dis[n] <= bus.din[5];
              end
              default: ;
            endcase
          end
        end
      end
      if (cen) begin
        for (int n = 0; n < CH; n++) begin
          if (k == KW'(n)) begin
            cnt[n]  <= wrap ? 12'd0 : cur_cnt + 12'd1;
            tone[n] <= tone_new;
          end
        end
        if (k == KLAST) begin
          sound    <= acc + contrib;
          acc      <= '0;
          sample_v <= 1'b1;
          k        <= '0;
        end else begin
          acc <= acc + contrib;
          k   <= k + KW'(1);
        end
      end
    end
  end

endmodule

// File: doc/jt49_tdm.md
JT49_TDM -- requirements
Module: jt49_tdm

Interface
REQ-001 SHALL have parameter CH, default 3, the number of tone channels; legal range 1..16.
REQ-002 SHALL have derived width DW = 4 + clog2(CH+1), the output sample width.
REQ-003 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port cen  input  1  clock enable; one channel is serviced per cen cycle.
REQ-006 SHALL have port addr  input  7  register address.
REQ-007 SHALL have port wr  input  1  write strobe, active-high, independent of cen.
REQ-008 SHALL have port din  input  8  write data.
REQ-009 SHALL have port dout  output  8  registered read data for addr.
REQ-010 SHALL have port sound  output  DW  mixed sample.
REQ-011 SHALL have port sample_v  output  1  one-clk pulse when sound updates.

Function
REQ-012 SHALL decode the register map per channel n (0..CH-1) as follows:
- addr 4n: period[7:0].
- addr 4n+1: period[11:8] in bits[3:0], upper bits read 0.
- addr 4n+2: vol in bits[3:0], noise_en in bit4, tone_dis in bit5, bits[7:6] read 0.
- addr 4n+3 and unmapped addresses: writes ignored, read 0.
- addr 0x40: noise period in bits[4:0].
REQ-013 SHALL give dout one clk latency: dout <= reg[addr] every clk; a write and read of the same address in the same clk returns the old value.
REQ-014 SHALL keep a channel index k, which increments on each cen and wraps from CH-1 to 0.
REQ-015 SHALL service channel k on cen using shared counter storage:
- Let Peff = max(period,1).
- If cnt_k+1 >= Peff: cnt_k <= 0 and tone_k toggles.
- Otherwise: cnt_k <= cnt_k+1.
REQ-016 SHALL make a period write take effect at that channel's next service; the >= rule covers a counter that is already above the new period.
REQ-017 SHALL compute the channel contribution as vol_k when (tone_k_updated | tone_dis) & (noise | ~noise_en), else 0.
REQ-018 SHALL accumulate contributions; when k = CH-1, sound <= acc + contribution, acc <= 0 and sample_v pulses high in the same clk; otherwise acc <= acc + contribution.
REQ-019 SHALL NOT overflow the accumulator, since DW holds CH*15.
REQ-020 SHALL update nothing except registers, dout and sample_v deassertion while cen is low.

Reset
REQ-021 SHALL clear all of the following on rst: registers, cnt_k, tone_k, k, acc, sound, sample_v, dout, and the noise divider; the LFSR loads 17'h1.
REQ-022 SHALL abort the frame in progress when rst asserts mid-frame; no sample_v is issued for the partial frame.

Configuration
REQ-023 SHALL compile in the noise generator when macro JT49_TDM_NOISE_EN is defined:
- The 5-bit noise divider is advanced at each frame end using the REQ-015 rule against reg 0x40.
- On its wrap, the 17-bit LFSR shifts right with new bit16 = bit0 ^ bit3.
- noise = LFSR bit0.
REQ-024 SHALL behave as follows when the macro is undefined:
- noise = 1.
- The noise_en bit has no audible effect.
- Addr 0x40 reads 0 and writes are ignored.

Verification
REQ-025 SHALL cover: CH=3, reset, no writes, cen held high -> sound=0 and sample_v on every 3rd cen.
REQ-026 SHALL cover: ch0 period=2, vol=15, other vols 0 -> per-frame sound 0,15,15,0,0,15,15.
REQ-027 SHALL cover: ch0 period=0 and vol=15 -> sound 15,0,15,0 (identical to period=1).
REQ-028 SHALL cover: all three channels tone_dis=1, vol=7, noise_en=0 -> sound=21 every frame.
REQ-029 SHALL cover: write 0xAB to addr 1 then read addr 1 -> dout=0x0B one clk later; same-clk read returns 0x00.
REQ-030 SHALL cover: with macro, ch0 tone_dis=1, noise_en=1, vol=15, noise period=0 -> sound equals 15*LFSR bit0 from seed 1, advancing one LFSR step per frame; without macro -> constant 15.
